// File: rtl/tt_check_pkg.sv
// Shared definitions for the truth-table response checker: FSM state
// encodings and the MISR seed and default feedback polynomial.
package tt_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] MISR_SEED         = 16'hFFFF;
    localparam logic [15:0] MISR_POLY_DEFAULT = 16'h8016;

endpackage

// File: rtl/tt_misr16.sv
// 16-bit multiple-input signature register. clr loads the seed, en folds
// one 16-bit word into the signature using the POLY feedback taps.
module tt_misr16
    import tt_check_pkg::*;
#(
    parameter logic [15:0] POLY = MISR_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    // Shift left with feedback from the MSB, then fold in the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 16'h0;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0) ^ din;
        end
    end

endmodule

// File: rtl/tt_response_checker.sv
// Receiving end of the exhaustive truth-table stimulus path. Accepts one
// response per vector, compares against EXP_TABLE, counts mismatches,
// remembers the first failing vector and flags out-of-order vectors.
// Optional feature: define TT_CHECK_MISR_SIGNATURE_EN to build a 16-bit
// MISR over every accepted {resp_vec,resp_data}; otherwise signature is 0.
module tt_response_checker
    import tt_check_pkg::*;
#(
    parameter int                          N_IN      = 4,
    parameter int                          N_OUT     = 2,
    parameter logic [(2**N_IN)*N_OUT-1:0]  EXP_TABLE = '0,
    parameter logic [15:0]                 MISR_POLY = MISR_POLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [N_IN-1:0]  resp_vec,
    input  logic [N_OUT-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_cnt,
    output logic [N_IN-1:0]  first_fail,
    output logic             seq_err,
    output logic [15:0]      signature
);

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    state_t            state;
    logic [N_IN-1:0]   vec_idx;
    logic [N_OUT-1:0]  exp_resp;
    logic              accept;
    logic              mismatch;
    logic              seq_bad;
    logic              run_start;
    logic [N_IN:0]     err_cnt_nxt;
    logic              seq_err_nxt;

    assign exp_resp    = EXP_TABLE[vec_idx*N_OUT +: N_OUT];
    assign accept      = resp_valid && resp_ready;
    assign seq_bad     = (resp_vec != vec_idx);
    assign run_start   = start && (state != ST_RUN);
    assign err_cnt_nxt = err_cnt + {{N_IN{1'b0}}, mismatch};
    assign seq_err_nxt = seq_err || seq_bad;

    // Any response that does not compare equal, including unknown bits,
    // is treated as a mismatch.
    always_comb begin
        mismatch = 1'b1;
        if (resp_data == exp_resp) begin
            mismatch = 1'b0;
        end
    end

    // Run control and result registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            resp_ready <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_idx    <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            seq_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        resp_ready <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        vec_idx    <= '0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        seq_err    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        err_cnt <= err_cnt_nxt;
                        seq_err <= seq_err_nxt;
                        vec_idx <= vec_idx + 1'b1;
                        if (mismatch && (err_cnt == '0)) begin
                            first_fail <= vec_idx;
                        end
                        if (vec_idx == LAST_VEC) begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            resp_ready <= 1'b0;
                            done       <= 1'b1;
                            pass       <= (err_cnt_nxt == '0) && !seq_err_nxt;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    resp_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef TT_CHECK_MISR_SIGNATURE_EN
    tt_misr16 #(
        .POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .en    (accept),
        .din   (16'({resp_vec, resp_data})),
        .sig   (signature)
    );
`else
    assign signature = 16'h0;
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Self-checking bench for tt_response_checker. Two instances share the
// stimulus: one with an all-zero expected table, one with a mixed table.
// A queue-based model of each run predicts every output each cycle.
module tb_tt_response_checker;

    localparam int          N_IN  = 4;
    localparam int          N_OUT = 2;
    localparam int          NV    = 16;
    localparam logic [31:0] TAB_A = 32'h0;
    localparam logic [31:0] TAB_B = 32'hB4E1_93C6;
    localparam logic [15:0] POLY  = 16'h8016;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        resp_valid = 1'b0;
    logic [3:0]  resp_vec = '0;
    logic [1:0]  resp_data = '0;

    logic        ready_a, busy_a, done_a, pass_a, seq_a;
    logic [4:0]  err_a;
    logic [3:0]  ff_a;
    logic [15:0] sig_a;
    logic        ready_b, busy_b, done_b, pass_b, seq_b;
    logic [4:0]  err_b;
    logic [3:0]  ff_b;
    logic [15:0] sig_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    tt_response_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .EXP_TABLE(TAB_A), .MISR_POLY(POLY)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp_ready(ready_a),
        .resp_vec(resp_vec), .resp_data(resp_data), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_fail(ff_a), .seq_err(seq_a), .signature(sig_a));

    tt_response_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .EXP_TABLE(TAB_B), .MISR_POLY(POLY)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp_ready(ready_b),
        .resp_vec(resp_vec), .resp_data(resp_data), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_fail(ff_b), .seq_err(seq_b), .signature(sig_b));

    always #5 clk = ~clk;

    // Reference: the list of beats accepted in the current run.
    int         nbeats = 0;
    logic [3:0] bvec [NV];
    logic [1:0] bdat [NV];
    bit         running = 1'b0;
    bit         finished = 1'b0;
    bit         started = 1'b0;

    // Track run boundaries and record accepted beats at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbeats   = 0;
            running  = 1'b0;
            finished = 1'b0;
            started  = 1'b0;
        end else if (running) begin
            if (resp_valid) begin
                bvec[nbeats] = resp_vec;
                bdat[nbeats] = resp_data;
                nbeats++;
                if (nbeats == NV) begin
                    running  = 1'b0;
                    finished = 1'b1;
                end
            end
        end else if (start) begin
            running  = 1'b1;
            finished = 1'b0;
            nbeats   = 0;
            started  = 1'b1;
        end
    end

    function automatic int m_err(input logic [31:0] tab);
        int n = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (bdat[i] != tab[i*2 +: 2]) n++;
        end
        return n;
    endfunction

    function automatic int m_first(input logic [31:0] tab);
        for (int i = 0; i < nbeats; i++) begin
            if (bdat[i] != tab[i*2 +: 2]) return i;
        end
        return 0;
    endfunction

    function automatic bit m_seq();
        for (int i = 0; i < nbeats; i++) begin
            if (int'(bvec[i]) != i) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_sig();
        logic [15:0] s;
`ifdef TT_CHECK_MISR_SIGNATURE_EN
        if (!started) return 16'h0;
        s = 16'hFFFF;
        for (int i = 0; i < nbeats; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0) ^ {10'b0, bvec[i], bdat[i]};
        end
`else
        s = 16'h0;
`endif
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busyA",  busy_a,  running);
            chk("readyA", ready_a, running);
            chk("doneA",  done_a,  finished);
            chk("passA",  pass_a,  finished && m_err(TAB_A) == 0 && !m_seq());
            chk("errA",   err_a,   m_err(TAB_A));
            chk("ffA",    ff_a,    m_first(TAB_A));
            chk("seqA",   seq_a,   m_seq());
            chk("sigA",   sig_a,   m_sig());
            chk("busyB",  busy_b,  running);
            chk("doneB",  done_b,  finished);
            chk("passB",  pass_b,  finished && m_err(TAB_B) == 0 && !m_seq());
            chk("errB",   err_b,   m_err(TAB_B));
            chk("ffB",    ff_b,    m_first(TAB_B));
            chk("seqB",   seq_b,   m_seq());
            chk("sigB",   sig_b,   m_sig());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [1:0] d, input int gaps, input bit with_start);
        for (int g = 0; g < gaps; g++) begin
            resp_valid = 1'b0;
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        resp_valid = 1'b1;
        resp_vec   = v;
        resp_data  = d;
        start      = with_start;
        tick();
        resp_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic runVectors(input logic [15:0] flip, input int bad_vec, input int gap_max,
                              input int start_at, input bit rand_data);
        logic [1:0] d;
        logic [3:0] v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NV; i++) begin
            d = rand_data ? 2'($urandom) : (flip[i] ? 2'b01 : 2'b00);
            v = (i == bad_vec) ? 4'(i + 1) : 4'(i);
            applyStimulus(v, d, gap_max > 0 ? $urandom_range(0, gap_max) : 0, i == start_at);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    logic [15:0] sig_zero;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        checkOutput("resetBusy", busy_a, 0);
        checkOutput("resetReady", ready_a, 0);
        tick();

        // Reset after five beats discards the run.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(4'(i), 2'b01, 0, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midResetBusy", busy_a, 0);
        checkOutput("midResetErr", err_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        runVectors(16'h0, -1, 0, -1, 1'b0);
        @(negedge clk);
        checkOutput("cleanDone", done_a, 1);
        checkOutput("cleanPass", pass_a, 1);
        checkOutput("cleanErr", err_a, 0);
        checkOutput("doneReady", ready_a, 0);
        sig_zero = sig_a;
        tick();

        // Mismatches on vectors 3 and 9.
        runVectors(16'h0208, -1, 0, -1, 1'b0);
        @(negedge clk);
        checkOutput("twoErrCnt", err_a, 2);
        checkOutput("twoErrFirst", ff_a, 3);
        checkOutput("twoErrPass", pass_a, 0);
`ifdef TT_CHECK_MISR_SIGNATURE_EN
        checkOutput("sigChanges", sig_a != sig_zero, 1);
`else
        checkOutput("sigZero", sig_a, 0);
`endif
        tick();

        // Vector 6 tagged as 7.
        runVectors(16'h0, 6, 0, -1, 1'b0);
        @(negedge clk);
        checkOutput("seqErr", seq_a, 1);
        checkOutput("seqPass", pass_a, 0);
        checkOutput("seqErrCnt", err_a, 0);
        tick();

        // Gaps, a start mid-run, and a start on the final beat.
        runVectors(16'h0, -1, 3, 7, 1'b0);
        @(negedge clk);
        checkOutput("gapPass", pass_a, 1);
        checkOutput("gapErr", err_a, 0);
        tick();
        runVectors(16'h0, -1, 2, 15, 1'b0);
        @(negedge clk);
        checkOutput("lastStartBusy", busy_a, 0);
        checkOutput("lastStartDone", done_a, 1);
        tick();

        // Randomized runs against the model.
        for (int r = 0; r < 8; r++) begin
            runVectors(16'h0, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 14) : -1,
                       $urandom_range(0, 3), $urandom_range(0, 20), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
